// File: rtl/uart_pkg.sv
// UART definitions shared by the receiver and the transmitter.
// UART_RX_PARITY_EN adds the PARITY state to the receiver state encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // Even parity: nonzero when data bits plus parity bit hold an odd number of ones.
  function automatic logic even_parity_err(input logic [7:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Serial-side and word-side signals of the oversampling UART receiver.
interface uart_rx_oversample_if #(
  parameter int DBIT = 8
);

  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, frame_err, parity_err
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, frame_err, parity_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Both stages reset to the line's idle level so no false edge appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver; samples each bit at its midpoint.
// Define UART_RX_PARITY_EN to receive and check an even parity bit after the data.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input logic                 clk,
  input logic                 reset,
  uart_rx_oversample_if.slave bus
);

  // Tick counter widens only when a 2-stop-bit interval needs it.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

  logic            rx_s;
  state_t          state_r;
  logic [SW-1:0]   s_r;
  logic [2:0]      n_r;
  logic [DBIT-1:0] b_r;
  logic [DBIT-1:0] dout_r;
  logic            done_r;
  logic            ferr_r;
`ifdef UART_RX_PARITY_EN
  logic            par_r;
  logic            perr_r;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // Frame FSM with tick/bit counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      s_r     <= '0;
      n_r     <= 3'd0;
      b_r     <= '0;
      dout_r  <= '0;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r   <= 1'b0;
      perr_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            s_r     <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s_r == SW'(MID_TICK)) begin
              if (!rx_s) begin
                state_r <= DATA;
                s_r     <= '0;
                n_r     <= 3'd0;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_r == SW'(OVERSAMPLE - 1)) begin
              s_r <= '0;
              b_r <= {rx_s, b_r[DBIT-1:1]};
              if (n_r == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= STOP;
`endif
              end else begin
                n_r <= n_r + 3'd1;
              end
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bus.s_tick) begin
            if (s_r == SW'(OVERSAMPLE - 1)) begin
              s_r     <= '0;
              par_r   <= rx_s;
              state_r <= STOP;
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          // A falling rx inside the stop interval is ignored until IDLE.
          if (bus.s_tick) begin
            if (s_r == SW'(SB_TICK - 1)) begin
              dout_r  <= b_r;
              ferr_r  <= ~rx_s;
              done_r  <= 1'b1;
              state_r <= IDLE;
`ifdef UART_RX_PARITY_EN
              perr_r  <= even_parity_err(8'(b_r), par_r);
`endif
            end else begin
              s_r <= s_r + SW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout         = dout_r;
  assign bus.rx_done_tick = done_r;
  assign bus.frame_err    = ferr_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_r;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: frames are queued when sent and
// matched against each rx_done_tick captured by the monitor.
module tb_uart_rx_oversample;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  localparam int BIT_CLK = 64;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  int   pulse_cnt;
  int   exp_total;
  logic [7:0] last_dout;
  rec_t exp_q[$];
  rec_t obs_q[$];

  uart_rx_oversample_if #(.DBIT(8)) bus ();

  uart_rx_oversample #(.DBIT(8), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick: one clk high every 4 clks
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.s_tick = 1'b1;
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
  end

  initial begin
    pulse_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.rx_done_tick === 1'b1) begin
        obs_q.push_back('{data: bus.dout, ferr: bus.frame_err, perr: bus.parity_err});
        pulse_cnt++;
      end
    end
  end

  task automatic send_bit(input logic b, input int cycles);
    bus.rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par);
    rec_t e;
    e.data = d;
    e.ferr = ~stop_ok;
`ifdef UART_RX_PARITY_EN
    e.perr = (^d) ^ par;
`else
    e.perr = 1'b0;
`endif
    exp_q.push_back(e);
    exp_total++;
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    send_bit(par, BIT_CLK);
`endif
    if (stop_ok) begin
      send_bit(1'b1, BIT_CLK);
    end else begin
      send_bit(1'b0, 40);
      send_bit(1'b1, BIT_CLK - 40);
    end
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.dout !== 8'h00 || bus.rx_done_tick !== 1'b0 || bus.frame_err !== 1'b0 || bus.parity_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got dout=%h done=%b ferr=%b perr=%b, expected 00 0 0 0",
               bus.dout, bus.rx_done_tick, bus.frame_err, bus.parity_err);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (dut.state_r !== IDLE || bus.dout !== 8'h00 || bus.rx_done_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got state=%0d dout=%h done=%b, expected IDLE 00 0",
               dut.state_r, bus.dout, bus.rx_done_tick);
    end
    last_dout = 8'h00;
  endtask

  task automatic test_valid_frame();
    rec_t e, o;
    send_frame(8'hA5, 1'b1, 1'b0);
    for (int g = 0; g < 200 && obs_q.size() < 1; g++) @(negedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      fails++;
      $display("FAIL valid_frame_count: got %0d pulses, expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL valid_frame: got dout=%h ferr=%b perr=%b, expected dout=%h ferr=%b perr=%b",
                 o.data, o.ferr, o.perr, e.data, e.ferr, e.perr);
      end
    end
    exp_q.delete();
    obs_q.delete();
    last_dout = 8'hA5;
  endtask

  task automatic test_frame_error();
    rec_t e, o;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      fails++;
      $display("FAIL frame_err_count: got %0d pulses, expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL frame_err: got dout=%h ferr=%b perr=%b, expected dout=%h ferr=%b perr=%b",
                 o.data, o.ferr, o.perr, e.data, e.ferr, e.perr);
      end
    end
    exp_q.delete();
    obs_q.delete();
    last_dout = 8'h3C;
  endtask

  task automatic test_glitch();
    send_bit(1'b0, 20);
    send_bit(1'b1, 3 * BIT_CLK);
    checks++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL glitch_pulse: got %0d pulses, expected 0", obs_q.size());
    end
    checks++;
    if (dut.state_r !== IDLE) begin
      fails++;
      $display("FAIL glitch_state: got state=%0d, expected IDLE", dut.state_r);
    end
    checks++;
    if (bus.dout !== last_dout || bus.frame_err !== 1'b1) begin
      fails++;
      $display("FAIL glitch_hold: got dout=%h ferr=%b, expected dout=%h ferr=1",
               bus.dout, bus.frame_err, last_dout);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_abort();
    rec_t e, o;
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) send_bit(1'b1, BIT_CLK);
    send_bit(1'b1, BIT_CLK / 2);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1, 12 * BIT_CLK);
    checks++;
    if (obs_q.size() != 0 || bus.dout !== 8'h00) begin
      fails++;
      $display("FAIL abort_no_pulse: got %0d pulses dout=%h, expected 0 pulses dout=00",
               obs_q.size(), bus.dout);
    end
    obs_q.delete();
    send_frame(8'h12, 1'b1, 1'b0);
    for (int g = 0; g < 200 && obs_q.size() < 1; g++) @(negedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      fails++;
      $display("FAIL abort_next_count: got %0d pulses, expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL abort_next: got dout=%h ferr=%b perr=%b, expected dout=%h ferr=%b perr=%b",
                 o.data, o.ferr, o.perr, e.data, e.ferr, e.perr);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0);
    for (int g = 0; g < 200 && obs_q.size() < 3; g++) @(negedge clk);
    checks++;
    if (obs_q.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses, expected 3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b_frame: got dout=%h ferr=%b perr=%b, expected dout=%h ferr=%b perr=%b",
                 o.data, o.ferr, o.perr, e.data, e.ferr, e.perr);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    rec_t e, o;
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    for (int g = 0; g < 200 && obs_q.size() < 2; g++) @(negedge clk);
    checks++;
    if (obs_q.size() != 2) begin
      fails++;
      $display("FAIL parity_count: got %0d pulses, expected 2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL parity_frame: got dout=%h ferr=%b perr=%b, expected dout=%h ferr=%b perr=%b",
                 o.data, o.ferr, o.perr, e.data, e.ferr, e.perr);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
    checks    = 0;
    fails     = 0;
    exp_total = 0;
    bus.rx    = 1'b1;
    reset     = 1'b1;
    test_reset();
    test_valid_frame();
    test_frame_error();
    test_glitch();
    test_reset_abort();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (pulse_cnt != exp_total) begin
      fails++;
      $display("FAIL total_pulses: got %0d, expected %0d", pulse_cnt, exp_total);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
